id_stage_hazard_pipe: RTL and testbench

- Parametrised next-generation instruction-decode stage for the MIPS pipeline.
- Sits between IF/ID and EX and owns the ID/EX pipeline register. Adds valid/ready handshakes on both sides, a multi-cycle load scoreboard (configurable load latency), register-jump hazard stalls, corrected jump targets and a saturating stall counter.
- Decoder control words and register-file read data arrive as inputs. Control unit and register bank stay external.

---
 rtl/id_stage_hazard_pipe_pkg.sv | 38 +++
 rtl/id_stage_hazard_pipe_load_scoreboard.sv | 53 +++++
 rtl/id_stage_hazard_pipe.sv | 166 ++++++++++++++++
 tb/tb_id_stage_hazard_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_hazard_pipe_pkg.sv
// Shared definitions for the ID stage: control-word bit positions and jump decode.
package id_pkg;

  // Bit positions inside the decoder control words
  localparam int unsigned CTRL_EX_JAL       = 10;
  localparam int unsigned CTRL_EX_J         = 9;
  localparam int unsigned CTRL_EX_JR        = 8;
  localparam int unsigned CTRL_EX_JALR      = 7;
  localparam int unsigned CTRL_MEM_MEMREAD  = 1;
  localparam int unsigned CTRL_WB_REGWRITE  = 1;

  typedef enum logic [2:0] {
    JT_NONE = 3'd0,
    JT_JAL  = 3'd1,
    JT_J    = 3'd2,
    JT_JR   = 3'd3,
    JT_JALR = 3'd4
  } jump_type_e;

  // Resolve the jump kind; JAL outranks J, J outranks JR, JR outranks JALR
  function automatic jump_type_e f_jump_type(input logic i_jal, input logic i_j,
                                             input logic i_jr, input logic i_jalr);
    jump_type_e v_t;
    if (i_jal) begin
      v_t = JT_JAL;
    end else if (i_j) begin
      v_t = JT_J;
    end else if (i_jr) begin
      v_t = JT_JR;
    end else if (i_jalr) begin
      v_t = JT_JALR;
    end else begin
      v_t = JT_NONE;
    end
    return v_t;
  endfunction

endpackage

// File: rtl/id_stage_hazard_pipe_load_scoreboard.sv
// Load scoreboard: tracks destinations of loads still in flight after ID.
// Entry 0 mirrors the ID/EX slot; older entries follow EX/MEM onward.
module load_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int NB_ADDR  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_shift,
  input  logic               i_kill0,
  input  logic               i_load,
  input  logic [NB_ADDR-1:0] i_dest,
  input  logic               i_chk_en,
  input  logic [NB_ADDR-1:0] i_rs,
  input  logic [NB_ADDR-1:0] i_rt,
  output logic               o_hit
);

  logic [LOAD_LAT-1:0]         r_v;
  logic [LOAD_LAT*NB_ADDR-1:0] r_dest;
  logic [LOAD_LAT:0]           w_v_next;
  logic [(LOAD_LAT+1)*NB_ADDR-1:0] w_dest_next;
  logic [LOAD_LAT-1:0]         w_match;

  // Padding the shift vectors keeps the LOAD_LAT=1 case free of empty slices
  assign w_v_next    = {r_v, i_load & ~i_kill0};
  assign w_dest_next = {r_dest, i_dest};

  // Shift on advance; a flush without advance only retires the ID/EX entry
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_v    <= '0;
      r_dest <= '0;
    end else if (i_shift) begin
      r_v    <= w_v_next[LOAD_LAT-1:0];
      r_dest <= w_dest_next[LOAD_LAT*NB_ADDR-1:0];
    end else if (i_kill0) begin
      r_v[0] <= 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LOAD_LAT; g++) begin : g_cmp
      assign w_match[g] = r_v[g] &
        (((i_rs != '0) & (i_rs == r_dest[g*NB_ADDR +: NB_ADDR])) |
         ((i_rt != '0) & (i_rt == r_dest[g*NB_ADDR +: NB_ADDR])));
    end
  endgenerate

  assign o_hit = i_chk_en & (|w_match);

endmodule

// File: rtl/id_stage_hazard_pipe.sv
// MIPS instruction-decode stage owning the ID/EX register, with handshakes,
// load/jump hazard stalls, jump target resolution and a stall counter.
module id_stage_hazard_pipe
  import id_pkg::*;
#(
  parameter int LEN                  = 32,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int LOAD_LAT             = 1,
  parameter int LINK_REG             = 31,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 9,
  parameter int NB_CTRL_EX           = 12,
  parameter int NB_STALL_CNT         = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [LEN-1:0]                  i_instruccion,
  input  logic [LEN-1:0]                  i_adder_pc,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_EX-1:0]           i_ctrl_ex,
  input  logic [LEN-1:0]                  i_dato1,
  input  logic [LEN-1:0]                  i_dato2,
  input  logic                            i_flush,
  input  logic                            i_ex_ready,
  output logic                            o_valid,
  output logic [LEN-1:0]                  o_adder_pc,
  output logic [LEN-1:0]                  o_dato1,
  output logic [LEN-1:0]                  o_dato2,
  output logic [LEN-1:0]                  o_sign_extend,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_rs,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_rt,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_rd,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_shamt,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
  output logic [NB_CTRL_EX-1:0]           o_ctrl_ex,
  output logic                            o_flag_stall,
  output logic                            o_flag_jump,
  output logic [LEN-1:0]                  o_dir_jump,
  output logic [NB_STALL_CNT-1:0]         o_stall_cnt
);

  localparam int NB = NB_ADDRESS_REGISTROS;

  logic          w_advance;
  logic          w_load_hazard;
  logic          w_jump_hazard;
  logic          w_hazard;
  logic          w_accept;
  logic [NB-1:0] w_rs;
  logic [NB-1:0] w_rt;
  logic [NB-1:0] w_rd;
  logic [NB-1:0] w_shamt;
  jump_type_e    w_jtype;

  assign w_rs    = i_instruccion[25:21];
  assign w_rt    = i_instruccion[20:16];
  assign w_rd    = i_instruccion[15:11];
  assign w_shamt = i_instruccion[10:6];

  assign w_advance = ~o_valid | i_ex_ready;

  load_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .NB_ADDR  (NB)
  ) u_scoreboard (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_shift  (w_advance),
    .i_kill0  (i_flush),
    .i_load   (w_accept & i_ctrl_mem[CTRL_MEM_MEMREAD]),
    .i_dest   (w_rt),
    .i_chk_en (i_valid),
    .i_rs     (w_rs),
    .i_rt     (w_rt),
    .o_hit    (w_load_hazard)
  );

  // A register jump must wait for a producer still sitting in ID/EX
  assign w_jump_hazard = i_valid & (i_ctrl_ex[CTRL_EX_JR] | i_ctrl_ex[CTRL_EX_JALR]) &
                         (w_rs != '0) & o_valid & o_ctrl_wb[CTRL_WB_REGWRITE] &
                         ((w_rs == o_rt) | (w_rs == o_rd));

  assign w_hazard     = w_load_hazard | w_jump_hazard;
  assign o_flag_stall = w_hazard & ~i_flush;
  // A flushed instruction is consumed so IF can move on
  assign o_ready      = i_flush | (w_advance & ~w_hazard);
  assign w_accept     = i_valid & o_ready & ~i_flush;

  // Jump kind is only meaningful for an instruction actually taken this cycle
  always_comb begin
    if (w_accept) begin
      w_jtype = f_jump_type(i_ctrl_ex[CTRL_EX_JAL], i_ctrl_ex[CTRL_EX_J],
                            i_ctrl_ex[CTRL_EX_JR], i_ctrl_ex[CTRL_EX_JALR]);
    end else begin
      w_jtype = JT_NONE;
    end
  end

  // Jump target: pseudo-direct for J/JAL, register value for JR/JALR
  always_comb begin
    case (w_jtype)
      JT_JAL, JT_J:   o_dir_jump = {i_adder_pc[LEN-1:28], i_instruccion[25:0], 2'b00};
      JT_JR, JT_JALR: o_dir_jump = i_dato1;
      default:        o_dir_jump = '0;
    endcase
  end

  assign o_flag_jump = (w_jtype != JT_NONE);

  // ID/EX register: flush kills, advance loads or bubbles, otherwise hold
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid       <= 1'b0;
      o_adder_pc    <= '0;
      o_dato1       <= '0;
      o_dato2       <= '0;
      o_sign_extend <= '0;
      o_rs          <= '0;
      o_rt          <= '0;
      o_rd          <= '0;
      o_shamt       <= '0;
      o_ctrl_wb     <= '0;
      o_ctrl_mem    <= '0;
      o_ctrl_ex     <= '0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      o_ctrl_wb  <= '0;
      o_ctrl_mem <= '0;
      o_ctrl_ex  <= '0;
    end else if (w_advance) begin
      if (w_accept) begin
        o_valid       <= 1'b1;
        o_adder_pc    <= i_adder_pc;
        o_dato1       <= i_dato1;
        o_dato2       <= i_dato2;
        o_sign_extend <= {{(LEN-16){i_instruccion[15]}}, i_instruccion[15:0]};
        o_rs          <= w_rs;
        o_rt          <= i_ctrl_ex[CTRL_EX_JAL] ? NB'(LINK_REG) : w_rt;
        o_rd          <= w_rd;
        o_shamt       <= w_shamt;
        o_ctrl_wb     <= i_ctrl_wb;
        o_ctrl_mem    <= i_ctrl_mem;
        o_ctrl_ex     <= i_ctrl_ex;
      end else begin
        o_valid    <= 1'b0;
        o_ctrl_wb  <= '0;
        o_ctrl_mem <= '0;
        o_ctrl_ex  <= '0;
      end
    end
  end

  // Saturating count of edges spent in a hazard stall
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_stall_cnt <= '0;
    end else if (o_flag_stall && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + NB_STALL_CNT'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_hazard_pipe.sv
// Bench: two instances (LOAD_LAT=3/16-bit counter and LOAD_LAT=1/2-bit counter)
// driven by the same stream and compared against a behavioural model.
module tb_id_stage_hazard_pipe;

  logic        clk = 1'b0;
  logic        t_rst = 1'b0;
  logic        t_valid = 1'b0;
  logic [31:0] t_instr = 32'd0;
  logic [31:0] t_pc = 32'd0;
  logic [1:0]  t_wb = 2'd0;
  logic [8:0]  t_mem = 9'd0;
  logic [11:0] t_ex = 12'd0;
  logic [31:0] t_d1 = 32'd0;
  logic [31:0] t_d2 = 32'd0;
  logic        t_flush = 1'b0;
  logic        t_exrdy = 1'b1;

  logic a_ready, a_valid, a_stall, a_jump, b_ready, b_valid, b_stall, b_jump;
  logic [31:0] a_pc, a_d1, a_d2, a_sx, a_dir, b_pc, b_d1, b_d2, b_sx, b_dir;
  logic [4:0]  a_rs, a_rt, a_rd, a_sh, b_rs, b_rt, b_rd, b_sh;
  logic [1:0]  a_wb, b_wb;
  logic [8:0]  a_mem, b_mem;
  logic [11:0] a_ex, b_ex;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  id_stage_hazard_pipe #(.LOAD_LAT(3), .NB_STALL_CNT(16)) dut_a (
    .i_clk(clk), .i_rst(t_rst), .i_valid(t_valid), .o_ready(a_ready),
    .i_instruccion(t_instr), .i_adder_pc(t_pc), .i_ctrl_wb(t_wb), .i_ctrl_mem(t_mem),
    .i_ctrl_ex(t_ex), .i_dato1(t_d1), .i_dato2(t_d2), .i_flush(t_flush),
    .i_ex_ready(t_exrdy), .o_valid(a_valid), .o_adder_pc(a_pc), .o_dato1(a_d1),
    .o_dato2(a_d2), .o_sign_extend(a_sx), .o_rs(a_rs), .o_rt(a_rt), .o_rd(a_rd),
    .o_shamt(a_sh), .o_ctrl_wb(a_wb), .o_ctrl_mem(a_mem), .o_ctrl_ex(a_ex),
    .o_flag_stall(a_stall), .o_flag_jump(a_jump), .o_dir_jump(a_dir), .o_stall_cnt(a_cnt));

  id_stage_hazard_pipe #(.LOAD_LAT(1), .NB_STALL_CNT(2)) dut_b (
    .i_clk(clk), .i_rst(t_rst), .i_valid(t_valid), .o_ready(b_ready),
    .i_instruccion(t_instr), .i_adder_pc(t_pc), .i_ctrl_wb(t_wb), .i_ctrl_mem(t_mem),
    .i_ctrl_ex(t_ex), .i_dato1(t_d1), .i_dato2(t_d2), .i_flush(t_flush),
    .i_ex_ready(t_exrdy), .o_valid(b_valid), .o_adder_pc(b_pc), .o_dato1(b_d1),
    .o_dato2(b_d2), .o_sign_extend(b_sx), .o_rs(b_rs), .o_rt(b_rt), .o_rd(b_rd),
    .o_shamt(b_sh), .o_ctrl_wb(b_wb), .o_ctrl_mem(b_mem), .o_ctrl_ex(b_ex),
    .o_flag_stall(b_stall), .o_flag_jump(b_jump), .o_dir_jump(b_dir), .o_stall_cnt(b_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ----------------
  int          lat  [2];
  int          cmax [2];
  bit          m_valid [2];
  logic [31:0] m_pc [2], m_d1 [2], m_d2 [2], m_sx [2];
  logic [4:0]  m_rs [2], m_rt [2], m_rd [2], m_sh [2];
  logic [1:0]  m_wb [2];
  logic [8:0]  m_mem [2];
  logic [11:0] m_ex [2];
  int          m_cnt [2];
  int          pend [2][4];   // in-flight load dests by age, -1 = none

  function automatic void mreset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = '0; m_d1[i] = '0; m_d2[i] = '0; m_sx[i] = '0;
      m_rs[i] = '0; m_rt[i] = '0; m_rd[i] = '0; m_sh[i] = '0;
      m_wb[i] = '0; m_mem[i] = '0; m_ex[i] = '0; m_cnt[i] = 0;
      for (int a = 0; a < 4; a++) pend[i][a] = -1;
    end
  endfunction

  function automatic void mcomb(input int i, output bit rdy, output bit st, output bit jp,
                                output bit acc, output bit adv, output logic [31:0] dir);
    int rs = int'(t_instr[25:21]);
    int rt = int'(t_instr[20:16]);
    bit ldh = 1'b0;
    bit jh, hz;
    adv = !m_valid[i] || t_exrdy;
    for (int a = 0; a < lat[i]; a++)
      if (pend[i][a] >= 0 && ((rs != 0 && rs == pend[i][a]) || (rt != 0 && rt == pend[i][a])))
        ldh = 1'b1;
    ldh = ldh && t_valid;
    jh  = t_valid && (t_ex[8] || t_ex[7]) && rs != 0 && m_valid[i] && m_wb[i][1] &&
          (rs == int'(m_rt[i]) || rs == int'(m_rd[i]));
    hz  = ldh || jh;
    st  = hz && !t_flush;
    rdy = t_flush || (adv && !hz);
    acc = t_valid && rdy && !t_flush;
    jp  = acc && (t_ex[10] || t_ex[9] || t_ex[8] || t_ex[7]);
    dir = 32'd0;
    if (acc && (t_ex[10] || t_ex[9])) dir = {t_pc[31:28], t_instr[25:0], 2'b00};
    else if (acc && (t_ex[8] || t_ex[7])) dir = t_d1;
  endfunction

  function automatic void mupd(input int i, input bit acc, input bit adv, input bit st);
    int nd;
    if (st && m_cnt[i] < cmax[i]) m_cnt[i]++;
    if (adv) begin
      nd = (acc && t_mem[1]) ? int'(t_instr[20:16]) : -1;
      for (int a = 3; a > 0; a--) pend[i][a] = pend[i][a-1];
      pend[i][0] = nd;
    end else if (t_flush) begin
      pend[i][0] = -1;
    end
    if (t_flush) begin
      m_valid[i] = 1'b0; m_wb[i] = '0; m_mem[i] = '0; m_ex[i] = '0;
    end else if (adv && acc) begin
      m_valid[i] = 1'b1; m_pc[i] = t_pc; m_d1[i] = t_d1; m_d2[i] = t_d2;
      m_sx[i] = 32'($signed(t_instr[15:0]));
      m_rs[i] = t_instr[25:21]; m_rt[i] = t_ex[10] ? 5'd31 : t_instr[20:16];
      m_rd[i] = t_instr[15:11]; m_sh[i] = t_instr[10:6];
      m_wb[i] = t_wb; m_mem[i] = t_mem; m_ex[i] = t_ex;
    end else if (adv) begin
      m_valid[i] = 1'b0; m_wb[i] = '0; m_mem[i] = '0; m_ex[i] = '0;
    end
  endfunction

  task automatic chk_regs(input string p, input int i, input logic v,
                          input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] sx, input logic [19:0] f, input logic [22:0] c,
                          input logic [31:0] cnt);
    chk({p, "_valid"}, {31'd0, v}, {31'd0, m_valid[i]});
    chk({p, "_pc"}, pc, m_pc[i]);
    chk({p, "_dato1"}, d1, m_d1[i]);
    chk({p, "_dato2"}, d2, m_d2[i]);
    chk({p, "_sext"}, sx, m_sx[i]);
    chk({p, "_fields"}, {12'd0, f}, {12'd0, m_rs[i], m_rt[i], m_rd[i], m_sh[i]});
    chk({p, "_ctrl"}, {9'd0, c}, {9'd0, m_wb[i], m_mem[i], m_ex[i]});
    chk({p, "_stall_cnt"}, cnt, m_cnt[i]);
  endtask

  // values sampled on the last posedge of step()
  bit          s_a_acc, s_b_acc, s_a_jump, s_a_ready;
  logic [31:0] s_a_dir;

  task automatic step();
    bit rdy [2], st [2], jp [2], acc [2], adv [2];
    logic [31:0] dir [2];
    @(posedge clk);
    for (int i = 0; i < 2; i++) mcomb(i, rdy[i], st[i], jp[i], acc[i], adv[i], dir[i]);
    chk("a_ready", {31'd0, a_ready}, {31'd0, rdy[0]});
    chk("a_stall", {31'd0, a_stall}, {31'd0, st[0]});
    chk("a_jump",  {31'd0, a_jump},  {31'd0, jp[0]});
    chk("a_dir",   a_dir, dir[0]);
    chk("b_ready", {31'd0, b_ready}, {31'd0, rdy[1]});
    chk("b_stall", {31'd0, b_stall}, {31'd0, st[1]});
    chk("b_jump",  {31'd0, b_jump},  {31'd0, jp[1]});
    chk("b_dir",   b_dir, dir[1]);
    s_a_acc   = t_valid && a_ready && !t_flush;
    s_b_acc   = t_valid && b_ready && !t_flush;
    s_a_jump  = a_jump;
    s_a_ready = a_ready;
    s_a_dir   = a_dir;
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) mupd(i, acc[i], adv[i], st[i]);
    chk_regs("a", 0, a_valid, a_pc, a_d1, a_d2, a_sx, {a_rs, a_rt, a_rd, a_sh},
             {a_wb, a_mem, a_ex}, {16'd0, a_cnt});
    chk_regs("b", 1, b_valid, b_pc, b_d1, b_d2, b_sx, {b_rs, b_rt, b_rd, b_sh},
             {b_wb, b_mem, b_ex}, {30'd0, b_cnt});
  endtask

  task automatic idle(input int n);
    t_valid = 1'b0;
    repeat (n) step();
  endtask

  // Present one instruction until dut_a takes it; report stall cycles seen by each DUT
  task automatic issue(input logic [31:0] ins, input logic [11:0] ex, input logic [8:0] mem,
                       input logic [1:0] wb, input logic [31:0] d1, output int sa, output int sb);
    t_valid = 1'b1; t_instr = ins; t_ex = ex; t_mem = mem; t_wb = wb; t_d1 = d1;
    t_d2 = ins ^ 32'h5a5a_0000;
    sa = -1; sb = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (sb < 0 && s_b_acc) sb = c;
      if (s_a_acc) begin
        sa = c;
        break;
      end
    end
    if (sa < 0) chk("issue_timeout", 32'd0, 32'd1);
    t_valid = 1'b0;
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  localparam logic [8:0]  MEM_RD = 9'b0_0000_0010;
  localparam logic [1:0]  WB_RW  = 2'b10;

  initial begin
    int sa, sb;
    lat[0] = 3; lat[1] = 1; cmax[0] = 65535; cmax[1] = 3;
    mreset();
    #2;
    chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_a_cnt", {16'd0, a_cnt}, 32'd0);
    chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
    #10 t_rst = 1'b1;

    // lw $7 then dependent uses: 3 stalls at LOAD_LAT=3, 1 at LOAD_LAT=1
    idle(2);
    issue(i_ins(6'h23, 0, 7, 16'h0004), 12'd0, MEM_RD, WB_RW, 32'd0, sa, sb);
    issue(r_ins(7, 7, 8), 12'd0, 9'd0, WB_RW, 32'd0, sa, sb);
    chk("ll3_use_stalls", 32'(sa), 32'd3);
    chk("ll1_use_stalls", 32'(sb), 32'd1);
    chk("ll1_cnt_one", {30'd0, b_cnt}, 32'd1);
    issue(r_ins(7, 0, 9), 12'd0, 9'd0, WB_RW, 32'd0, sa, sb);
    chk("ll3_second_use", 32'(sa), 32'd0);
    issue(r_ins(0, 7, 10), 12'd0, 9'd0, WB_RW, 32'd0, sa, sb);

    // an independent instruction in between shortens the stall to 2
    idle(4);
    issue(i_ins(6'h23, 0, 7, 16'h0000), 12'd0, MEM_RD, WB_RW, 32'd0, sa, sb);
    issue(r_ins(1, 2, 10), 12'd0, 9'd0, WB_RW, 32'd0, sa, sb);
    issue(r_ins(7, 7, 8), 12'd0, 9'd0, WB_RW, 32'd0, sa, sb);
    chk("ll3_gap_stalls", 32'(sa), 32'd2);
    chk("ll1_gap_stalls", 32'(sb), 32'd0);

    // jal 0x40 from PC+4 = 0x80000008
    idle(4);
    t_pc = 32'h8000_0008;
    issue({6'h03, 26'h000_0040}, 12'h400, 9'd0, WB_RW, 32'd0, sa, sb);
    chk("jal_target", s_a_dir, 32'h8000_0100);
    chk("jal_flag", {31'd0, s_a_jump}, 32'd1);
    chk("jal_link_rt", {27'd0, a_rt}, 32'd31);

    // jr $9 right after addi $9: one stall, then the target is the register value
    issue(i_ins(6'h08, 0, 9, 16'h0000), 12'd0, 9'd0, WB_RW, 32'd0, sa, sb);
    issue({6'd0, 5'd9, 21'h8}, 12'h100, 9'd0, 2'b00, 32'h1234_5678, sa, sb);
    chk("jr_stalls", 32'(sa), 32'd1);
    chk("jr_target", s_a_dir, 32'h1234_5678);

    // EX back-pressure with a valid entry, then a flush in the middle of the hold
    issue(r_ins(1, 2, 3), 12'h003, 9'h005, WB_RW, 32'hAA, sa, sb);
    t_exrdy = 1'b0; t_valid = 1'b1; t_instr = r_ins(4, 5, 6);
    repeat (3) begin
      step();
      chk("hold_ready", {31'd0, s_a_ready}, 32'd0);
      chk("hold_valid", {31'd0, a_valid}, 32'd1);
    end
    t_flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, a_valid}, 32'd0);
    chk("flush_ctrl", {9'd0, a_wb, a_mem, a_ex}, 32'd0);
    t_flush = 1'b0; t_exrdy = 1'b1;

    // asynchronous reset in the middle of a load stall
    idle(4);
    issue(i_ins(6'h23, 0, 5, 16'h0000), 12'd0, MEM_RD, WB_RW, 32'd0, sa, sb);
    t_valid = 1'b1; t_instr = r_ins(5, 5, 6); t_mem = 9'd0;
    step();
    @(posedge clk);
    #2 t_rst = 1'b0;
    #1;
    mreset();
    chk("arst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("arst_a_cnt", {16'd0, a_cnt}, 32'd0);
    chk("arst_b_cnt", {30'd0, b_cnt}, 32'd0);
    chk("arst_a_stall", {31'd0, a_stall}, 32'd0);
    @(negedge clk);
    #1 t_rst = 1'b1;
    step();
    idle(3);

    // drive the 2-bit counter past saturation
    for (int k = 0; k < 4; k++) begin
      issue(i_ins(6'h23, 0, 5, 16'h0000), 12'd0, MEM_RD, WB_RW, 32'd0, sa, sb);
      issue(r_ins(5, 5, 6), 12'd0, 9'd0, WB_RW, 32'd0, sa, sb);
    end
    chk("b_cnt_saturated", {30'd0, b_cnt}, 32'd3);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      t_valid = ($urandom_range(3) != 0);
      t_instr = $urandom;
      t_instr[25:21] = 5'($urandom_range(7));
      t_instr[20:16] = 5'($urandom_range(7));
      t_instr[15:11] = 5'($urandom_range(7));
      t_pc    = $urandom;
      t_d1    = $urandom;
      t_d2    = $urandom;
      t_ex    = 12'($urandom) & 12'hC7F;
      for (int b = 7; b <= 10; b++) t_ex[b] = ($urandom_range(7) == 0);
      t_mem   = 9'($urandom);
      t_mem[1] = ($urandom_range(2) == 0);
      t_wb    = 2'($urandom);
      t_exrdy = ($urandom_range(4) != 0);
      t_flush = ($urandom_range(19) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
